// File: rtl/rriot_bus_master.sv
// Bus initiator for the 6530 RRIOT: turns valid/ready requests into 6502-style
// bus cycles and generates the free-running two-phase phi2 clock for the device.
`timescale 1ns/1ps
module rriot_bus_master #(
    parameter int HALF_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [9:0] req_addr,
    input  logic       req_rs0,
    input  logic       req_cs1,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       phi2,
    output logic       we_n,
    output logic [9:0] A,
    output logic [7:0] dev_di,
    output logic       RS0,
    output logic       CS1,
    input  logic [7:0] dev_do,
    input  logic       dev_oe
);

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             wrap, eoc, accept;
    logic             load_bus, clear_bus, complete;

    // Writes report 0x00/ok; a read with nobody driving the bus reports 0xFF/err.
    function automatic logic [DATA_W:0] resolve_rsp(input logic is_write, input logic oe,
                                                    input logic [DATA_W-1:0] rd);
        if (is_write) return '0;
        if (oe)       return {1'b0, rd};
        return {1'b1, {DATA_W{1'b1}}};
    endfunction

    assign wrap      = (cnt == CNT_LAST);
    assign eoc       = phi2 && wrap;
    assign req_ready = eoc && ((state == IDLE) || (state == DATA));
    assign accept    = req_valid && req_ready;

    // Phase generator: runs in every state so the device keeps clocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            phi2 <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 1'b1;
            phi2 <= phi2 ^ wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADDR;
            ADDR:    if (wrap && !phi2) state_nxt = DATA;
            DATA:    if (eoc) state_nxt = accept ? ADDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_bus  = accept;
        complete  = (state == DATA) && eoc;
        clear_bus = complete && !accept;
    end

    // Bus stage: held for a full phi2 period per accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A      <= '0;
            RS0    <= 1'b0;
            CS1    <= 1'b0;
            we_n   <= 1'b1;
            dev_di <= '0;
        end else if (load_bus) begin
            A      <= req_addr;
            RS0    <= req_rs0;
            CS1    <= req_cs1;
            we_n   <= ~req_we;
            dev_di <= req_wdata;
        end else if (clear_bus) begin
            A      <= {ADDR_W{1'b0}};
            RS0    <= 1'b0;
            CS1    <= 1'b0;
            we_n   <= 1'b1;
            dev_di <= {DATA_W{1'b0}};
        end
    end

    // Response stage: captured at the end of the phi2-high phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= complete;
            if (complete) {rsp_err, rsp_rdata} <= resolve_rsp(!we_n, dev_oe, dev_do);
        end
    end

endmodule

// File: tb/tb_rriot_bus_master.sv
// Randomised scoreboard bench for rriot_bus_master, run at HALF_PERIOD=2 and =1
// against a behavioural 6530 stub (64-byte RAM at 0x0C0..0x0FF, ROM on RS0&CS1).
`timescale 1ns/1ps
module tb_rriot_bus_master;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } rsp_t;

    int   checks   = 0;
    int   failures = 0;
    logic clk      = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input int hp, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL hp%0d %s actual=0x%0h required=0x%0h", hp, name, act, exp);
        end
    endtask

    function automatic logic [7:0] rom_byte(input logic [9:0] a);
        return a[7:0] ^ {a[9:8], a[9:8], a[9:8], 2'b01};
    endfunction

    function automatic logic in_ram(input logic rs0, input logic [9:0] a);
        return !rs0 && (a >= 10'h0C0) && (a <= 10'h0FF);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int HP = (g == 0) ? 2 : 1;

        logic       rst_n = 1'b1;
        logic       req_valid = 1'b0, req_we = 1'b0, req_rs0 = 1'b0, req_cs1 = 1'b0;
        logic [9:0] req_addr = '0;
        logic [7:0] req_wdata = '0;
        logic       req_ready, rsp_valid, rsp_err, phi2, we_n, RS0, CS1, dev_oe;
        logic [9:0] A;
        logic [7:0] rsp_rdata, dev_di, dev_do;
        logic       done = 1'b0;
        int         cyc;
        rsp_t       exp_q[$];
        logic       win_on = 1'b0;
        int         win_start = 0;
        logic [9:0] win_a = '0;
        logic       win_we_n = 1'b1, win_rs0 = 1'b0, win_cs1 = 1'b0;
        logic [7:0] win_di = '0;
        logic [7:0] dmem    [64];
        logic [7:0] ref_ram [64];

        rriot_bus_master #(.HALF_PERIOD(HP)) dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
            .req_addr(req_addr), .req_rs0(req_rs0), .req_cs1(req_cs1), .req_wdata(req_wdata),
            .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
            .phi2(phi2), .we_n(we_n), .A(A), .dev_di(dev_di), .RS0(RS0), .CS1(CS1),
            .dev_do(dev_do), .dev_oe(dev_oe)
        );

        // Device stub
        assign dev_do = (RS0 && CS1) ? rom_byte(A) : dmem[A[5:0]];
        assign dev_oe = phi2 && we_n && ((RS0 && CS1) || (!RS0 && A[9:6] == 4'h3));
        always @(posedge phi2)
            if (!we_n && !RS0 && A[9:6] == 4'h3) dmem[A[5:0]] <= dev_di;

        always @(posedge clk or negedge rst_n)
            if (!rst_n) cyc <= 0;
            else        cyc <= cyc + 1;

        // Monitor
        always @(negedge clk) begin
            if (rst_n) begin
                chk(HP, "phi2", phi2, (cyc / HP) % 2);
                if (win_on && cyc < win_start + 2 * HP) begin
                    chk(HP, "bus_A", A, win_a);
                    chk(HP, "bus_we_n", we_n, win_we_n);
                    chk(HP, "bus_RS0", RS0, win_rs0);
                    chk(HP, "bus_CS1", CS1, win_cs1);
                    chk(HP, "bus_di", dev_di, win_di);
                end else begin
                    chk(HP, "idle_bus", {A, we_n, RS0, CS1, dev_di}, {10'h000, 1'b1, 1'b0, 1'b0, 8'h00});
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk(HP, "rsp_unexpected", 1, 0);
                    end else begin
                        rsp_t e;
                        e = exp_q.pop_front();
                        chk(HP, "rsp_rdata", rsp_rdata, e.rdata);
                        chk(HP, "rsp_err", rsp_err, e.err);
                        chk(HP, "rsp_cycle", cyc, e.cyc);
                    end
                end
            end
        end

        task automatic check_reset_vals(input string tag);
            chk(HP, {tag, "_rsp_valid"}, rsp_valid, 0);
            chk(HP, {tag, "_rsp_rdata"}, rsp_rdata, 0);
            chk(HP, {tag, "_rsp_err"}, rsp_err, 0);
            chk(HP, {tag, "_phi2"}, phi2, 0);
            chk(HP, {tag, "_req_ready"}, req_ready, 0);
            chk(HP, {tag, "_bus"}, {A, we_n, RS0, CS1, dev_di}, {10'h000, 1'b1, 1'b0, 1'b0, 8'h00});
        endtask

        task automatic issue(input logic we, input logic [9:0] addr, input logic rs0,
                             input logic cs1, input logic [7:0] wdata, output int acc);
            int   n;
            rsp_t e;
            req_valid = 1'b1;
            req_we    = we;
            req_addr  = addr;
            req_rs0   = rs0;
            req_cs1   = cs1;
            req_wdata = wdata;
            n = 0;
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!req_ready) begin
                chk(HP, "accept_timeout", 0, 1);
                req_valid = 1'b0;
                acc = -1;
                return;
            end
            @(posedge clk);
            #1;
            acc = cyc;
            if (we) begin
                e.rdata = 8'h00;
                e.err   = 1'b0;
                if (in_ram(rs0, addr)) ref_ram[addr[5:0]] = wdata;
            end else if (in_ram(rs0, addr)) begin
                e.rdata = ref_ram[addr[5:0]];
                e.err   = 1'b0;
            end else if (rs0 && cs1) begin
                e.rdata = rom_byte(addr);
                e.err   = 1'b0;
            end else begin
                e.rdata = 8'hFF;
                e.err   = 1'b1;
            end
            e.cyc = acc + 2 * HP;
            exp_q.push_back(e);
            win_on    = 1'b1;
            win_start = acc;
            win_a     = addr;
            win_we_n  = ~we;
            win_rs0   = rs0;
            win_cs1   = cs1;
            win_di    = wdata;
            req_valid = 1'b0;
        endtask

        task automatic drain();
            int n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk(HP, "drain", exp_q.size(), 0);
            @(negedge clk);
        endtask

        initial begin
            int acc, a0, a1, a2;
            #1 rst_n = 1'b0;
            #1 check_reset_vals("por");
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;

            issue(1'b1, 10'h0C5, 1'b0, 1'b0, 8'hA5, acc);
            chk(HP, "first_accept", acc, 2 * HP);
            drain();
            issue(1'b0, 10'h0C5, 1'b0, 1'b0, 8'h00, acc);
            drain();
            issue(1'b0, 10'h3FF, 1'b1, 1'b1, 8'h00, acc);
            drain();
            issue(1'b0, 10'h000, 1'b0, 1'b0, 8'h00, acc);
            drain();
            issue(1'b1, 10'h0C0, 1'b0, 1'b1, 8'h3C, acc);
            issue(1'b0, 10'h0C0, 1'b0, 1'b1, 8'h00, acc);
            drain();

            issue(1'b0, 10'h0C5, 1'b0, 1'b0, 8'h00, a0);
            issue(1'b0, 10'h0C0, 1'b0, 1'b0, 8'h00, a1);
            issue(1'b0, 10'h155, 1'b1, 1'b1, 8'h00, a2);
            chk(HP, "b2b_gap1", a1 - a0, 2 * HP);
            chk(HP, "b2b_gap2", a2 - a1, 2 * HP);
            drain();

            // Reset in the middle of the phi2-high phase of a read
            issue(1'b0, 10'h2AA, 1'b1, 1'b1, 8'h00, acc);
            repeat (HP + 1) @(negedge clk);
            rst_n = 1'b0;
            exp_q.delete();
            win_on = 1'b0;
            #1 check_reset_vals("mid_rst");
            repeat (3) @(posedge clk);
            @(negedge clk);
            check_reset_vals("mid_rst_hold");
            rst_n = 1'b1;
            issue(1'b0, 10'h2AA, 1'b1, 1'b1, 8'h00, acc);
            chk(HP, "accept_after_rst", acc, 2 * HP);
            drain();

            for (int i = 0; i < 64; i++)
                issue(1'b1, 10'h0C0 | 10'(i), 1'b0, 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), acc);
            drain();

            for (int i = 0; i < 40; i++) begin
                logic [9:0] addr;
                logic       rs0, cs1;
                int         kind;
                kind = $urandom_range(0, 3);
                addr = 10'($urandom_range(0, 1023));
                if (kind <= 1) begin
                    addr = 10'h0C0 | {4'h0, addr[5:0]};
                    rs0  = 1'b0;
                    cs1  = 1'($urandom_range(0, 1));
                end else if (kind == 2) begin
                    rs0 = 1'b1;
                    cs1 = 1'b1;
                end else if ($urandom_range(0, 1) == 1) begin
                    rs0 = 1'b1;
                    cs1 = 1'b0;
                end else begin
                    rs0 = 1'b0;
                    cs1 = 1'($urandom_range(0, 1));
                    if (in_ram(1'b0, addr)) addr = addr ^ 10'h200;
                end
                issue(1'($urandom_range(0, 1)), addr, rs0, cs1, 8'($urandom_range(0, 255)), acc);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            drain();
            done = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(h[0].done && h[1].done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(0, "sim_complete", h[0].done && h[1].done, 1);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rriot_bus_master.md
# rriot_bus_master

Bus initiator for the 6530 RRIOT responder. It turns single read/write requests on a valid/ready port into 6502-style bus cycles. It also generates the two-phase `phi2` clock that the device uses as its clock, drives address, data, `we_n` and the selects, and captures `DO`/`OE` at the end of each read cycle. It sits between a test or host controller and the 6530 core in the same design.

## Interface
- `HALF_PERIOD`, default 2: number of `clk` cycles per `phi2` phase (low and high). Must be ≥1.
- `clk` in 1: system clock; all logic runs on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a `clk` edge where `req_valid & req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 10: target address.
- `req_rs0` in 1: ROM select value for the cycle.
- `req_cs1` in 1: CS1 value for the cycle.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-`clk` pulse when a cycle completes.
- `rsp_rdata` out 8: read data, valid with `rsp_valid`.
- `rsp_err` out 1: read found `dev_oe` low.
- `phi2` out 1: generated device clock.
- `we_n` out 1: bus R/W.
- `A` out 10: bus address.
- `dev_di` out 8: data to the device.
- `RS0` out 1: ROM select to the device.
- `CS1` out 1: chip select to the device.
- `dev_do` in 8: device read data.
- `dev_oe` in 1: device is driving `dev_do`.

## Operation
- **Phase generator.**
  - Counter `cnt` runs 0..HALF_PERIOD-1. `phi2` is registered and toggles on the edge where `cnt` wraps.
  - `phi2` is free-running in every state, so device RAM and ROM keep clocking.
- **Cycle boundary.** The boundary is the last `clk` of a `phi2`-high phase (`phi2==1 && cnt==HALF_PERIOD-1`), written `EOC` below.
- **FSM states.**
  - IDLE: bus at idle values.
  - ADDR: `phi2` low phase of an active cycle.
  - DATA: `phi2` high phase of an active cycle.
- **Accepting a request.**
  - `req_ready` = `EOC && (state==IDLE || state==DATA)`. It is combinational, so back-to-back cycles have no idle gap.
  - On acceptance, the next state is ADDR and `A`, `RS0`, `CS1`, `dev_di` and `we_n` (= `~req_we`) are registered.
  - These bus outputs stay stable through ADDR and DATA, i.e. 2×HALF_PERIOD `clk` cycles.
- **State transitions.**
  - ADDR → DATA when `phi2` rises.
  - DATA at EOC → ADDR if a new request is accepted, otherwise IDLE.
- **Bus values at IDLE.**
  - Used when leaving DATA with no new request: `A`=0x000, `RS0`=0, `CS1`=0, `we_n`=1, `dev_di`=0x00.
  - These values select neither RAM nor ROM.
- **Completion (at DATA EOC).**
  - Read:
    - `dev_oe==1`: `rsp_rdata` ← `dev_do`, `rsp_err` ← 0.
    - `dev_oe==0`: `rsp_rdata` ← 0xFF, `rsp_err` ← 1.
  - Write: `rsp_rdata` ← 0x00, `rsp_err` ← 0.
  - In all cases `rsp_valid` is 1 for the following `clk` cycle only.
- **Response flow control.** `rsp_valid` has no backpressure; the consumer must take it.
- **Reset (asynchronous, any state).**
  - `phi2`=0, `cnt`=0, state IDLE, bus outputs at idle values.
  - `rsp_valid`=0, `rsp_rdata`=0x00, `rsp_err`=0.
  - A cycle in flight is abandoned and produces no response.

## Timing
- `phi2` period is 2×HALF_PERIOD `clk` cycles, 50% duty.
- After reset deassertion, `phi2` is low for HALF_PERIOD clks, then high.
  - The first EOC is the 2×HALF_PERIOD-th `clk` edge.
  - The earliest acceptance is at that edge.
- Setup and sampling for a request accepted at edge E:
  - Bus outputs change at E, so the address leads the `phi2` rise by HALF_PERIOD clks.
  - The device samples writes on the `phi2` rise at E+HALF_PERIOD.
  - Read data is sampled at E+2×HALF_PERIOD.
- Latency: `rsp_valid` is high in the cycle after edge E+2×HALF_PERIOD.
- Throughput: one bus cycle per `phi2` period.
- With HALF_PERIOD=1, `cnt` is constant 0 and EOC = `phi2==1`.
- With a new request accepted at DATA EOC, the bus outputs change at the same edge as the previous response registers.

## Test plan
- Reset: assert `rst_n`=0 mid-DATA of a read, hold 3 clks, release → all outputs at reset values, no `rsp_valid`; first `req_ready` at the 4th `clk` edge after release (HALF_PERIOD=2).
- RAM write then read:
  - Write 0xA5 to `A`=0x0C5 (`rs0`=0, `cs1`=0); `we_n` low for 4 clks, `rsp_valid` once with `err`=0.
  - Read 0x0C5 → `rsp_rdata`=0xA5, `rsp_err`=0.
- ROM read: `rs0`=1, `cs1`=1, `A`=0x3FF → `rsp_rdata` equals the ROM image byte at 0x3FF, `rsp_err`=0, `rsp_valid` 4 clks after acceptance.
- Unselected read: `A`=0x000, `rs0`=0, `cs1`=0 → `rsp_rdata`=0xFF, `rsp_err`=1.
- Back-to-back:
  - Hold `req_valid` for 3 reads → acceptances 4 clks apart.
  - `A` never returns to 0x000 between cycles; 3 `rsp_valid` pulses 4 clks apart.
- HALF_PERIOD=1: `phi2` toggles every clk; write 0x3C to 0x0C0 then read → 0x3C; latency 2 clks.
